// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS controller, datapath and immediate extender.
// FSM state codes, opcode/funct constants, datapath select values and the decode class bundle.
package mc_pkg;

  typedef enum logic [2:0] {
    StReset  = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5
  } state_e;

  localparam logic [5:0] OpR    = 6'b000000;
  localparam logic [5:0] OpOri  = 6'b001101;
  localparam logic [5:0] OpLw   = 6'b100011;
  localparam logic [5:0] OpSw   = 6'b101011;
  localparam logic [5:0] OpBeq  = 6'b000100;
  localparam logic [5:0] OpLui  = 6'b001111;
  localparam logic [5:0] OpJ    = 6'b000010;
  localparam logic [5:0] OpJal  = 6'b000011;

  localparam logic [5:0] FnSll  = 6'b000000;
  localparam logic [5:0] FnAddu = 6'b100001;
  localparam logic [5:0] FnSubu = 6'b100011;
  localparam logic [5:0] FnJr   = 6'b001000;

  localparam logic [1:0] ExtSign  = 2'b00;
  localparam logic [1:0] ExtZero  = 2'b01;
  localparam logic [1:0] ExtUpper = 2'b10;

  localparam logic [2:0] AluAdd   = 3'b000;
  localparam logic [2:0] AluSub   = 3'b001;
  localparam logic [2:0] AluOr    = 3'b010;
  localparam logic [2:0] AluPassB = 3'b011;

  localparam logic [1:0] RegDstRt = 2'b00;
  localparam logic [1:0] RegDstRd = 2'b01;
  localparam logic [1:0] RegDstRa = 2'b10;

  localparam logic [1:0] MtrAlu = 2'b00;
  localparam logic [1:0] MtrMem = 2'b01;
  localparam logic [1:0] MtrPc4 = 2'b10;

  localparam logic [1:0] NpcSeq    = 2'b00;
  localparam logic [1:0] NpcBranch = 2'b01;
  localparam logic [1:0] NpcJump   = 2'b10;
  localparam logic [1:0] NpcReg    = 2'b11;

  // One bit per supported instruction; at most one is set, none for an illegal encoding.
  typedef struct packed {
    logic addu;
    logic subu;
    logic jr;
    logic nop;
    logic ori;
    logic lw;
    logic sw;
    logic beq;
    logic lui;
    logic j;
    logic jal;
  } instr_cls_t;

  function automatic logic cls_is_rtype(instr_cls_t c);
    return c.addu | c.subu;
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: opcode/funct to a one-hot class plus an illegal flag.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output instr_cls_t cls,
  output logic       illegal
);

  always_comb begin
    cls     = '0;
    illegal = 1'b0;
    unique case (opcode)
      OpR: begin
        unique case (funct)
          FnAddu:  cls.addu = 1'b1;
          FnSubu:  cls.subu = 1'b1;
          FnJr:    cls.jr   = 1'b1;
          // Only the all-zero sll (nop) is supported; shift amount is not seen here.
          FnSll:   cls.nop  = 1'b1;
          default: illegal  = 1'b1;
        endcase
      end
      OpOri:   cls.ori = 1'b1;
      OpLw:    cls.lw  = 1'b1;
      OpSw:    cls.sw  = 1'b1;
      OpBeq:   cls.beq = 1'b1;
      OpLui:   cls.lui = 1'b1;
      OpJ:     cls.j   = 1'b1;
      OpJal:   cls.jal = 1'b1;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM for the single-issue MIPS core (fetch/decode/exec/mem/writeback).
// Define MC_CTRL_PERF_EN to add the cycle_cnt and retire_cnt performance counters.
module mc_ctrl
  import mc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        pc_wr,
  output logic        ir_wr,
  output logic        reg_wr,
  output logic [1:0]  ext_op,
  output logic        alu_src,
  output logic [2:0]  alu_op,
  output logic [1:0]  reg_dst,
  output logic [1:0]  mem_to_reg,
  output logic [1:0]  npc_op,
  output logic [31:0] pc_init,
  output logic        illegal,
  output logic [2:0]  state
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] retire_cnt
`endif
);

  state_e     state_q, state_d;
  instr_cls_t cls;
  logic       dec_illegal;
  logic       ends_in_decode;
  logic       goes_mem;
  logic       goes_wb;

  mc_decode u_decode (
    .opcode  (opcode),
    .funct   (funct),
    .cls     (cls),
    .illegal (dec_illegal)
  );

  assign ends_in_decode = cls.j | cls.jal | cls.jr | cls.nop | dec_illegal;
  assign goes_mem       = cls.lw | cls.sw;
  assign goes_wb        = cls_is_rtype(cls) | cls.ori | cls.lui;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StReset:  state_d = StFetch;
      StFetch:  if (mem_ready) state_d = StDecode;
      StDecode: state_d = ends_in_decode ? StFetch : StExec;
      StExec: begin
        if (goes_mem)     state_d = StMem;
        else if (goes_wb) state_d = StWb;
        else              state_d = StFetch;
      end
      StMem:    if (mem_ready) state_d = cls.lw ? StWb : StFetch;
      StWb:     state_d = StFetch;
      default:  state_d = StReset;
    endcase
  end

`ifdef MC_CTRL_PERF_EN
  logic [31:0] cycle_cnt_q;
  logic [31:0] retire_cnt_q;
  logic        retire;

  // An instruction retires when any post-fetch state hands control back to FETCH.
  assign retire = (state_q != StReset) && (state_q != StFetch) && (state_d == StFetch);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StReset;
`ifdef MC_CTRL_PERF_EN
      cycle_cnt_q  <= '0;
      retire_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
`ifdef MC_CTRL_PERF_EN
      if (state_q != StReset) cycle_cnt_q <= cycle_cnt_q + 32'd1;
      if (retire)             retire_cnt_q <= retire_cnt_q + 32'd1;
`endif
    end
  end

  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    pc_wr      = 1'b0;
    ir_wr      = 1'b0;
    reg_wr     = 1'b0;
    ext_op     = ExtSign;
    alu_src    = 1'b0;
    alu_op     = AluAdd;
    reg_dst    = RegDstRt;
    mem_to_reg = MtrAlu;
    npc_op     = NpcSeq;
    illegal    = 1'b0;

    // ALU selects stay valid from EXEC through WB so the datapath needs no result latch.
    if (state_q inside {StExec, StMem, StWb}) begin
      if (cls.subu | cls.beq) alu_op = AluSub;
      if (cls.ori) begin
        ext_op  = ExtZero;
        alu_src = 1'b1;
        alu_op  = AluOr;
      end
      if (cls.lui) begin
        ext_op  = ExtUpper;
        alu_src = 1'b1;
        alu_op  = AluPassB;
      end
      if (goes_mem) alu_src = 1'b1;
    end

    unique case (state_q)
      StFetch: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_wr = 1'b1;
          pc_wr = 1'b1;
        end
      end
      StDecode: begin
        illegal = dec_illegal;
        if (cls.j | cls.jal) begin
          pc_wr  = 1'b1;
          npc_op = NpcJump;
        end
        if (cls.jal) begin
          reg_wr     = 1'b1;
          reg_dst    = RegDstRa;
          mem_to_reg = MtrPc4;
        end
        if (cls.jr) begin
          pc_wr  = 1'b1;
          npc_op = NpcReg;
        end
      end
      StExec: begin
        if (cls.beq) begin
          pc_wr  = zero;
          npc_op = NpcBranch;
        end
      end
      StMem: begin
        mem_req = 1'b1;
        mem_we  = cls.sw;
      end
      StWb: begin
        reg_wr = 1'b1;
        if (cls_is_rtype(cls)) reg_dst = RegDstRd;
        if (cls.lw)            mem_to_reg = MtrMem;
      end
      default: ;
    endcase
  end

  assign state   = state_q;
  assign pc_init = RESET_PC;

`ifdef MC_CTRL_PERF_EN
  assign cycle_cnt  = cycle_cnt_q;
  assign retire_cnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: directed and random instructions against a transaction-level
// model giving state sequence, write-enable counts and select values per instruction.
module tb_mc_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  opcode = '0;
  logic [5:0]  funct = '0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b1;
  logic        mem_req, mem_we, pc_wr, ir_wr, reg_wr, alu_src, illegal;
  logic [1:0]  ext_op, reg_dst, mem_to_reg, npc_op;
  logic [2:0]  alu_op, state;
  logic [31:0] pc_init;
`ifdef MC_CTRL_PERF_EN
  logic [31:0] cycle_cnt, retire_cnt;
  int unsigned cyc_since_rst = 0;
  int unsigned ret_since_rst = 0;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mc_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .pc_wr      (pc_wr),
    .ir_wr      (ir_wr),
    .reg_wr     (reg_wr),
    .ext_op     (ext_op),
    .alu_src    (alu_src),
    .alu_op     (alu_op),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .npc_op     (npc_op),
    .pc_init    (pc_init),
    .illegal    (illegal),
    .state      (state)
`ifdef MC_CTRL_PERF_EN
    ,
    .cycle_cnt  (cycle_cnt),
    .retire_cnt (retire_cnt)
`endif
  );

  typedef enum {KAddu, KSubu, KJr, KNop, KOri, KLw, KSw, KBeq, KLui, KJ, KJal, KIll} kind_e;

  function automatic kind_e classify(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00: begin
        case (fn)
          6'h21:   return KAddu;
          6'h23:   return KSubu;
          6'h08:   return KJr;
          6'h00:   return KNop;
          default: return KIll;
        endcase
      end
      6'h0d:   return KOri;
      6'h23:   return KLw;
      6'h2b:   return KSw;
      6'h04:   return KBeq;
      6'h0f:   return KLui;
      6'h02:   return KJ;
      6'h03:   return KJal;
      default: return KIll;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] all_outs();
    return {mem_req, mem_we, pc_wr, ir_wr, reg_wr, ext_op, alu_src, alu_op,
            reg_dst, mem_to_reg, npc_op, illegal};
  endfunction

  // Runs one instruction from its first FETCH cycle; fw/mw are wait cycles in FETCH/MEM.
  task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                           input logic zb, input int fw, input int mw);
    int         seq[$];
    kind_e      k;
    bit         is_mem, is_wb, is_exec;
    int         n_pc = 0, n_ir = 0, n_reg = 0, n_ill = 0, n_req = 0, n_we = 0, trace_bad = 0;
    int         exp_pc, exp_reg;
    logic [1:0] npc_seen = 'x, rd_seen = 'x, mtr_seen = 'x, exp_npc, exp_rd, exp_mtr;
    logic [5:0] sel_ex = 'x, sel_wb = 'x, sel_exp;
    k       = classify(op, fn);
    is_mem  = k inside {KLw, KSw};
    is_wb   = k inside {KAddu, KSubu, KOri, KLui, KLw};
    is_exec = is_mem || is_wb || (k == KBeq);
    for (int i = 0; i <= fw; i++) seq.push_back(1);
    seq.push_back(2);
    if (is_exec) seq.push_back(3);
    if (is_mem) for (int i = 0; i <= mw; i++) seq.push_back(4);
    if (is_wb) seq.push_back(5);

    opcode = op;
    funct  = fn;
    for (int i = 0; i < seq.size(); i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      zero      = 1'($urandom_range(0, 1));
      if (seq[i] == 1) mem_ready = (i == fw);
      if (seq[i] == 4) mem_ready = (i == seq.size() - 1) || (seq[i+1] != 4);
      if (seq[i] == 3) zero = zb;
      #1;
      if (state !== 3'(seq[i])) trace_bad++;
      if (pc_wr)   n_pc++;
      if (ir_wr)   n_ir++;
      if (reg_wr)  n_reg++;
      if (illegal) n_ill++;
      if (mem_req) n_req++;
      if (mem_we)  n_we++;
      if (pc_wr && !ir_wr) npc_seen = npc_op;
      if (reg_wr) begin
        rd_seen  = reg_dst;
        mtr_seen = mem_to_reg;
        sel_wb   = {ext_op, alu_src, alu_op};
      end
      if (seq[i] == 3) sel_ex = {ext_op, alu_src, alu_op};
      @(posedge clk);
      #1;
    end

    exp_pc  = 1 + ((k inside {KJ, KJal, KJr}) ? 1 : 0) + ((k == KBeq && zb) ? 1 : 0);
    exp_reg = (is_wb || k == KJal) ? 1 : 0;
    exp_npc = (k == KJr) ? 2'b11 : (k == KBeq) ? 2'b01 : 2'b10;
    exp_rd  = (k inside {KAddu, KSubu}) ? 2'b01 : (k == KJal) ? 2'b10 : 2'b00;
    exp_mtr = (k == KLw) ? 2'b01 : (k == KJal) ? 2'b10 : 2'b00;
    case (k)
      KSubu, KBeq: sel_exp = 6'b00_0_001;
      KOri:        sel_exp = 6'b01_1_010;
      KLui:        sel_exp = 6'b10_1_011;
      KLw, KSw:    sel_exp = 6'b00_1_000;
      default:     sel_exp = 6'b00_0_000;
    endcase

    check({name, ".trace"},   64'(trace_bad), 64'd0);
    check({name, ".end"},     64'(state), 64'd1);
    check({name, ".pc_wr"},   64'(n_pc), 64'(exp_pc));
    check({name, ".ir_wr"},   64'(n_ir), 64'd1);
    check({name, ".reg_wr"},  64'(n_reg), 64'(exp_reg));
    check({name, ".illegal"}, 64'(n_ill), 64'((k == KIll) ? 1 : 0));
    check({name, ".mem_req"}, 64'(n_req), 64'(fw + 1 + (is_mem ? mw + 1 : 0)));
    check({name, ".mem_we"},  64'(n_we), 64'((k == KSw) ? mw + 1 : 0));
    if (exp_pc == 2) check({name, ".npc_op"}, 64'(npc_seen), 64'(exp_npc));
    if (exp_reg == 1) begin
      check({name, ".reg_dst"},    64'(rd_seen), 64'(exp_rd));
      check({name, ".mem_to_reg"}, 64'(mtr_seen), 64'(exp_mtr));
    end
    if (is_exec) check({name, ".sel_exec"}, 64'(sel_ex), 64'(sel_exp));
    if (is_wb)   check({name, ".sel_wb"},   64'(sel_wb), 64'(sel_exp));
`ifdef MC_CTRL_PERF_EN
    cyc_since_rst += seq.size();
    ret_since_rst++;
`endif
  endtask

  logic [5:0] op_tab [11] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h0d, 6'h23, 6'h2b, 6'h04,
                              6'h0f, 6'h02, 6'h03};
  logic [5:0] fn_tab [4]  = '{6'h21, 6'h23, 6'h08, 6'h00};

  initial begin
    logic [5:0] rop, rfn;
    int         pick;

    // Reset held for three cycles with mem_ready high: controller must stay quiet.
    repeat (3) @(posedge clk);
    #1;
    check("reset.state", 64'(state), 64'd0);
    check("reset.outs", 64'(all_outs()), 64'd0);
    check("pc_init", 64'(pc_init), 64'h0000_3000);
`ifdef MC_CTRL_PERF_EN
    check("reset.cycle_cnt", 64'(cycle_cnt), 64'd0);
    check("reset.retire_cnt", 64'(retire_cnt), 64'd0);
`endif
    rst_n = 1'b1;
    #1;
    check("release.state", 64'(state), 64'd0);
    check("release.outs", 64'(all_outs()), 64'd0);
    @(posedge clk);
    #1;
    check("first_fetch.state", 64'(state), 64'd1);
    check("first_fetch.wr", 64'({pc_wr, ir_wr, reg_wr}), 64'b110);

    run_instr("addu",     6'h00, 6'h21, 1'b0, 0, 0);
    run_instr("lw_wait2", 6'h23, 6'h15, 1'b0, 0, 2);
    run_instr("beq_t",    6'h04, 6'h07, 1'b1, 0, 0);
    run_instr("beq_nt",   6'h04, 6'h07, 1'b0, 0, 0);
    run_instr("lui",      6'h0f, 6'h3c, 1'b0, 0, 0);
    run_instr("ori",      6'h0d, 6'h01, 1'b0, 1, 0);
    run_instr("jal",      6'h03, 6'h2a, 1'b0, 0, 0);
    run_instr("ill_op",   6'h3f, 6'h00, 1'b0, 0, 0);
    run_instr("ill_fn",   6'h00, 6'h3f, 1'b0, 0, 0);
    run_instr("subu",     6'h00, 6'h23, 1'b1, 2, 0);
    run_instr("sw",       6'h2b, 6'h11, 1'b0, 0, 1);
    run_instr("j",        6'h02, 6'h00, 1'b0, 0, 0);
    run_instr("jr",       6'h00, 6'h08, 1'b0, 1, 0);
    run_instr("nop",      6'h00, 6'h00, 1'b0, 0, 0);

    for (int n = 0; n < 60; n++) begin
      pick = $urandom_range(0, 11);
      if (pick == 11) begin
        do begin
          rop = 6'($urandom);
          rfn = 6'($urandom);
        end while (classify(rop, rfn) != KIll);
      end else begin
        rop = op_tab[pick];
        rfn = (pick < 4) ? fn_tab[pick] : 6'($urandom);
      end
      run_instr($sformatf("rnd%0d", n), rop, rfn, 1'($urandom_range(0, 1)),
                $urandom_range(0, 2), $urandom_range(0, 2));
    end

`ifdef MC_CTRL_PERF_EN
    check("perf.cycle_cnt", 64'(cycle_cnt), 64'(cyc_since_rst));
    check("perf.retire_cnt", 64'(retire_cnt), 64'(ret_since_rst));
`endif

    // sw interrupted by reset while its store is pending in MEM.
    opcode    = 6'h2b;
    funct     = 6'h00;
    mem_ready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    mem_ready = 1'b0;
    #1;
    check("sw_abort.in_mem", 64'({state, mem_req, mem_we}), 64'({3'd4, 2'b11}));
    rst_n = 1'b0;
    #1;
    check("sw_abort.async_state", 64'(state), 64'd0);
    check("sw_abort.async_outs", 64'(all_outs()), 64'd0);
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    check("sw_abort.held", 64'({state, mem_we}), 64'd0);
`ifdef MC_CTRL_PERF_EN
    check("sw_abort.cycle_cnt", 64'(cycle_cnt), 64'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("sw_abort.refetch", 64'(state), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
